// File: rtl/bird_controller.sv
// Frame-rate Flappy Bird sequencer: one physics step per vsync falling edge,
// driving the bird row consumed by the 640x480 display timing block.
module bird_controller #(
  parameter int Y_START   = 240,
  parameter int Y_MAX     = 460,
  parameter int FLAP_VEL  = -8,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 8,
  parameter int DEAD_HOLD = 60
) (
  input  logic        dclk,
  input  logic        clr_n,
  input  logic        vsync,
  input  logic        flap,
  output logic [9:0]  bird_y,
  output logic [1:0]  state,
  output logic        frame_tick,
  output logic [15:0] frames_alive
);

  localparam int HW = $clog2(DEAD_HOLD + 1);
  localparam logic signed [5:0]  FLAP_V    = 6'(FLAP_VEL);
  localparam logic signed [5:0]  GRAV_V    = 6'(GRAVITY);
  localparam logic signed [5:0]  MAX_V     = 6'(MAX_FALL);
  localparam logic [9:0]         Y_START_V = 10'(Y_START);
  localparam logic [9:0]         Y_FLAP_V  = 10'(Y_START + FLAP_VEL);
  localparam logic [9:0]         Y_MAX_V   = 10'(Y_MAX);
  localparam logic signed [11:0] Y_MAX_S   = 12'(Y_MAX);
  localparam logic [HW-1:0]      HOLD_V    = HW'(DEAD_HOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAY    = 2'b01,
    DEAD    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t             cur_state, next_state;
  logic               vsync_d, tick;
  logic               flap_s1, flap_s2, flap_s3, flap_rise, flap_pending, flap_now;
  logic signed [5:0]  vel, vel_next, vel_try;
  logic signed [11:0] y_sum;
  logic [9:0]         y_next;
  logic [15:0]        alive_next;
  logic [HW-1:0]      hold_cnt, hold_next;

  assign tick      = vsync_d & ~vsync;
  assign flap_rise = flap_s2 & ~flap_s3;
  // A rise landing on the tick cycle is counted in that same tick.
  assign flap_now  = flap_pending | flap_rise;
  assign state     = cur_state;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vsync_d      <= 1'b1;
      frame_tick   <= 1'b0;
      flap_s1      <= 1'b0;
      flap_s2      <= 1'b0;
      flap_s3      <= 1'b0;
      flap_pending <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= tick;
      flap_s1    <= flap;
      flap_s2    <= flap_s1;
      flap_s3    <= flap_s2;
      if (frame_tick)
        flap_pending <= 1'b0;
      else if (flap_rise)
        flap_pending <= 1'b1;
    end
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      cur_state    <= IDLE;
      bird_y       <= Y_START_V;
      vel          <= '0;
      frames_alive <= '0;
      hold_cnt     <= '0;
    end else begin
      cur_state    <= next_state;
      bird_y       <= y_next;
      vel          <= vel_next;
      frames_alive <= alive_next;
      hold_cnt     <= hold_next;
    end
  end

  always_comb begin
    next_state = cur_state;
    y_next     = bird_y;
    vel_next   = vel;
    alive_next = frames_alive;
    hold_next  = hold_cnt;
    vel_try    = vel;
    y_sum      = '0;
    case (cur_state)
      IDLE: begin
        y_next = Y_START_V;
        if (frame_tick && flap_now) begin
          vel_next   = FLAP_V;
          y_next     = Y_FLAP_V;
          alive_next = '0;
          next_state = PLAY;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (flap_now)
            vel_try = FLAP_V;
          else if (vel + GRAV_V > MAX_V)
            vel_try = MAX_V;
          else
            vel_try = vel + GRAV_V;
          y_sum = $signed({2'b00, bird_y}) + $signed({{6{vel_try[5]}}, vel_try});
          // Ceiling clamps without killing; the floor kills.
          if (y_sum[11]) begin
            y_next   = '0;
            vel_next = '0;
          end else if (y_sum >= Y_MAX_S) begin
            y_next     = Y_MAX_V;
            vel_next   = '0;
            hold_next  = '0;
            next_state = DEAD;
          end else begin
            y_next   = y_sum[9:0];
            vel_next = vel_try;
            if (frames_alive != 16'hFFFF)
              alive_next = frames_alive + 16'd1;
          end
        end
      end
      DEAD: begin
        if (frame_tick) begin
          if (hold_cnt < HOLD_V)
            hold_next = hold_cnt + HW'(1);
          else if (flap_now) begin
            next_state = IDLE;
            y_next     = Y_START_V;
            vel_next   = '0;
          end
        end
      end
      default: begin
        next_state = IDLE;
        y_next     = Y_START_V;
        vel_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bird_controller.sv
// Self-checking bench for bird_controller: scenario tasks plus a randomized run
// compared against a frame-level game model.
module tb_bird_controller;

  logic        dclk = 1'b0;
  logic        clr_n = 1'b0;
  logic        vsync = 1'b1;
  logic        flap = 1'b0;
  logic [9:0]  bird_y;
  logic [1:0]  state;
  logic        frame_tick;
  logic [15:0] frames_alive;

  int checks = 0;
  int failures = 0;
  int tick_count = 0;
  int wide_ticks = 0;
  logic prev_tick = 1'b0;

  int m_state, m_y, m_vel, m_fa, m_hold;

  bird_controller dut (
    .dclk         (dclk),
    .clr_n        (clr_n),
    .vsync        (vsync),
    .flap         (flap),
    .bird_y       (bird_y),
    .state        (state),
    .frame_tick   (frame_tick),
    .frames_alive (frames_alive)
  );

  always #20 dclk = ~dclk;

  always @(negedge dclk) begin
    if (frame_tick) begin
      tick_count++;
      if (prev_tick) wide_ticks++;
    end
    prev_tick = frame_tick;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Game rules applied once per frame at the granularity of whole frames.
  task automatic model_tick(input bit f);
    int nv, ny;
    case (m_state)
      0: if (f) begin
        m_vel = -8; m_y = 240 - 8; m_fa = 0; m_state = 1;
      end
      1: begin
        nv = f ? -8 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
        ny = m_y + nv;
        if (ny < 0) begin
          m_y = 0; m_vel = 0;
        end else if (ny >= 460) begin
          m_y = 460; m_vel = 0; m_hold = 0; m_state = 2;
        end else begin
          m_y = ny; m_vel = nv;
          if (m_fa < 65535) m_fa++;
        end
      end
      default: begin
        if (m_hold < 60) m_hold++;
        else if (f) begin
          m_state = 0; m_y = 240; m_vel = 0;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge dclk);
    clr_n = 1'b0; vsync = 1'b1; flap = 1'b0;
    repeat (3) @(negedge dclk);
    clr_n = 1'b1;
    repeat (2) @(negedge dclk);
    m_state = 0; m_y = 240; m_vel = 0; m_fa = 0; m_hold = 0;
  endtask

  // One frame: vsync high with optional flap pulse(s), then a vsync low phase
  // producing exactly one tick. coinc makes the synchronized rise land on the tick.
  task automatic run_frame(input bit do_flap, input bit dbl, input bit coinc);
    int high_len;
    high_len = 14 + $urandom_range(0, 6);
    for (int i = 0; i < high_len; i++) begin
      @(negedge dclk);
      vsync = 1'b1;
      if (do_flap && i == 2) flap = 1'b1;
      if (do_flap && i == 5) flap = 1'b0;
      if (dbl && i == 8) flap = 1'b1;
      if (dbl && i == 10) flap = 1'b0;
      if (coinc && i == high_len - 1) flap = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge dclk);
      vsync = 1'b0;
    end
    @(negedge dclk);
    flap = 1'b0;
    vsync = 1'b1;
    model_tick(do_flap | dbl | coinc);
  endtask

  task automatic test_reset();
    int base, wide0;
    @(negedge dclk);
    clr_n = 1'b0;
    #1;
    checks++;
    if ({state, bird_y, frame_tick, frames_alive} !== {2'b00, 10'd240, 1'b0, 16'd0}) begin
      failures++;
      $display("[TB] FAIL reset_values: got state=%0d y=%0d tick=%0b alive=%0d, want 0/240/0/0",
               state, bird_y, frame_tick, frames_alive);
    end
    do_reset();
    base = tick_count; wide0 = wide_ticks;
    repeat (3) run_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if (tick_count - base !== 3) begin
      failures++;
      $display("[TB] FAIL tick_count: got %0d, want 3", tick_count - base);
    end
    checks++;
    if (wide_ticks !== wide0) begin
      failures++;
      $display("[TB] FAIL tick_width: got %0d multi-cycle ticks, want 0", wide_ticks - wide0);
    end
    checks++;
    if ({state, bird_y} !== {2'b00, 10'd240}) begin
      failures++;
      $display("[TB] FAIL idle_hold: got state=%0d y=%0d, want 0/240", state, bird_y);
    end
  endtask

  task automatic test_start_flap();
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if ({state, bird_y, frames_alive} !== {2'b01, 10'd232, 16'd0}) begin
      failures++;
      $display("[TB] FAIL start_flap: got state=%0d y=%0d alive=%0d, want 1/232/0",
               state, bird_y, frames_alive);
    end
    run_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if ({state, bird_y, frames_alive} !== {2'b01, 10'd225, 16'd1}) begin
      failures++;
      $display("[TB] FAIL first_gravity: got state=%0d y=%0d alive=%0d, want 1/225/1",
               state, bird_y, frames_alive);
    end
  endtask

  task automatic test_free_fall();
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0);
    for (int t = 2; t <= 45; t++) begin
      run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if ({state, bird_y, frames_alive} !== {2'(m_state), 10'(m_y), 16'(m_fa)}) begin
        failures++;
        $display("[TB] FAIL free_fall t=%0d: got %0d/%0d/%0d, want %0d/%0d/%0d",
                 t, state, bird_y, frames_alive, m_state, m_y, m_fa);
      end
      if (t == 17) begin
        checks++;
        if (bird_y !== 10'd240) begin
          failures++;
          $display("[TB] FAIL fall_t17: got y=%0d, want 240", bird_y);
        end
      end
      if (t == 44) begin
        checks++;
        if (bird_y !== 10'd456) begin
          failures++;
          $display("[TB] FAIL fall_t44: got y=%0d, want 456", bird_y);
        end
      end
    end
    checks++;
    if ({state, bird_y} !== {2'b10, 10'd460}) begin
      failures++;
      $display("[TB] FAIL floor_death: got state=%0d y=%0d, want 2/460", state, bird_y);
    end
  endtask

  task automatic test_dead_hold();
    int hold_bad;
    hold_bad = 0;
    for (int t = 1; t <= 60; t++) begin
      run_frame(1'b1, 1'b0, 1'b0);
      checks++;
      if ({state, bird_y, frames_alive} !== {2'b10, 10'd460, 16'(m_fa)}) begin
        failures++;
        $display("[TB] FAIL dead_hold t=%0d: got state=%0d y=%0d alive=%0d, want 2/460/%0d",
                 t, state, bird_y, frames_alive, m_fa);
      end
    end
    run_frame(1'b0, 1'b0, 1'b1);
    checks++;
    if ({state, bird_y} !== {2'b00, 10'd240}) begin
      failures++;
      $display("[TB] FAIL dead_restart: got state=%0d y=%0d, want 0/240", state, bird_y);
    end
  endtask

  task automatic test_ceiling();
    int exp_y;
    do_reset();
    for (int n = 1; n <= 31; n++) begin
      run_frame(1'b1, (n % 2) == 0, 1'b0);
      exp_y = (240 - 8 * n < 0) ? 0 : 240 - 8 * n;
      checks++;
      if ({state, bird_y} !== {2'b01, 10'(exp_y)} || m_y !== exp_y) begin
        failures++;
        $display("[TB] FAIL ceiling n=%0d: got state=%0d y=%0d, want 1/%0d",
                 n, state, bird_y, exp_y);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      r = $urandom_range(0, 9);
      run_frame(r < 2, r == 3, r == 2);
      checks++;
      if ({state, bird_y, frames_alive} !== {2'(m_state), 10'(m_y), 16'(m_fa)}) begin
        failures++;
        $display("[TB] FAIL random k=%0d: got %0d/%0d/%0d, want %0d/%0d/%0d",
                 k, state, bird_y, frames_alive, m_state, m_y, m_fa);
      end
    end
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 60 && m_y < 300; k++)
      run_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if ({state, bird_y} !== {2'b01, 10'(m_y)} || m_y < 300) begin
      failures++;
      $display("[TB] FAIL pre_reset: got state=%0d y=%0d, want 1/%0d", state, bird_y, m_y);
    end
    @(posedge dclk);
    #7;
    clr_n = 1'b0;
    #2;
    checks++;
    if ({state, bird_y, frame_tick, frames_alive} !== {2'b00, 10'd240, 1'b0, 16'd0}) begin
      failures++;
      $display("[TB] FAIL async_reset: got state=%0d y=%0d tick=%0b alive=%0d, want 0/240/0/0",
               state, bird_y, frame_tick, frames_alive);
    end
    repeat (2) @(negedge dclk);
    clr_n = 1'b1;
    m_state = 0; m_y = 240; m_vel = 0; m_fa = 0; m_hold = 0;
    base = tick_count;
    repeat (2) run_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if ({state, bird_y, frames_alive} !== {2'b00, 10'd240, 16'd0} || tick_count - base !== 2) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: got state=%0d y=%0d alive=%0d ticks=%0d, want 0/240/0/2",
               state, bird_y, frames_alive, tick_count - base);
    end
  endtask

  initial begin
    $display("[TB] bird_controller bench start");
    test_reset();
    test_start_flap();
    test_free_fall();
    test_dead_hold();
    test_ceiling();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
